// File: rtl/mult_pkg.sv
// Shared types and constants for the mult_8_bit handshake wrapper.
// The FSM encoding and the window geometry are used by the top and the aligner.
package mult_pkg;

  localparam int OP_W       = 8;
  localparam int PROD_W     = 16;
  localparam int NUM_PHASES = 4;
  localparam int PHASE_W    = 2;
  // Counter must reach NUM_PHASES-1+ACC_LAG with ACC_LAG up to 3.
  localparam int CNT_W      = 3;

  localparam logic [PHASE_W-1:0] LAST_PHASE = PHASE_W'(NUM_PHASES - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ALIGN = 3'd1,
    RUN   = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_e;

endpackage

// File: rtl/mult_phase_align.sv
// Finds the start of a four-phase nibble window on the multiplier's phase tap
// and counts cycles from that window start (t0) through RUN and DRAIN.
module mult_phase_align
  import mult_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               req_i,
  input  logic               active_i,
  input  logic [PHASE_W-1:0] mul_state_i,
  output logic               start_o,
  output logic [CNT_W-1:0]   cnt_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Phase 3 in this cycle means phase 0 (t0) in the next one.
  assign start_o = req_i && (mul_state_i == LAST_PHASE);

  always_comb begin
    cnt_d = cnt_q;
    if (start_o) begin
      cnt_d = '0;
    end else if (active_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/mult_op_seq.sv
// Valid/ready front/back end for mult_8_bit: holds operands over one aligned
// nibble window and recovers the product as a difference of accumulator snapshots.
module mult_op_seq
  import mult_pkg::*;
#(
  parameter int ACC_LAG = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   in_a,
  input  logic [OP_W-1:0]   in_b,
  output logic [OP_W-1:0]   mul_a,
  output logic [OP_W-1:0]   mul_b,
  input  logic [PHASE_W-1:0] mul_state,
  input  logic [PROD_W-1:0] mul_out,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [PROD_W-1:0] res_prod,
  output logic              busy
);

  localparam logic [CNT_W-1:0] BASE_CNT  = CNT_W'(ACC_LAG - 1);
  localparam logic [CNT_W-1:0] RUN_LAST  = CNT_W'(NUM_PHASES - 1);
  localparam logic [CNT_W-1:0] DRAIN_END = CNT_W'(NUM_PHASES - 1 + ACC_LAG);

  state_e            state_q;
  logic              in_ready_q;
  logic              res_valid_q;
  logic              busy_q;
  logic [OP_W-1:0]   mul_a_q;
  logic [OP_W-1:0]   mul_b_q;
  logic [PROD_W-1:0] base_q;
  logic [PROD_W-1:0] res_prod_q;

  logic              accept;
  logic              align_req;
  logic              window_active;
  logic              t0_next;
  logic [CNT_W-1:0]  cnt;

  assign accept        = (state_q == IDLE) && in_valid && in_ready_q;
  assign align_req     = accept || (state_q == ALIGN);
  assign window_active = (state_q == RUN) || (state_q == DRAIN);

  mult_phase_align u_align (
    .clk         (clk),
    .rst         (rst),
    .req_i       (align_req),
    .active_i    (window_active),
    .mul_state_i (mul_state),
    .start_o     (t0_next),
    .cnt_o       (cnt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      res_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      base_q      <= '0;
      res_prod_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            mul_a_q    <= in_a;
            mul_b_q    <= in_b;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            // Accepting on phase 3 skips ALIGN entirely.
            state_q    <= t0_next ? RUN : ALIGN;
          end
        end
        ALIGN: begin
          if (t0_next) begin
            state_q <= RUN;
          end
        end
        RUN: begin
          // Snapshot taken just before phase 0's contribution lands on mul_out.
          if (cnt == BASE_CNT) begin
            base_q <= mul_out;
          end
          if (cnt == RUN_LAST) begin
            state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (cnt == DRAIN_END) begin
            // Modular difference: accumulator wrap cancels out.
            res_prod_q  <= mul_out - base_q;
            res_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (res_ready) begin
            res_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b1;
          res_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign res_valid = res_valid_q;
  assign busy      = busy_q;
  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;
  assign res_prod  = res_prod_q;

endmodule

// File: tb/tb_mult_op_seq.sv
// Bench for mult_op_seq with a behavioural four-phase nibble multiplier
// (free-running phase counter, never-cleared accumulator, one cycle of lag).
module tb_mult_op_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_a;
  logic [7:0]  in_b;
  logic [7:0]  mul_a;
  logic [7:0]  mul_b;
  logic [1:0]  mul_state;
  logic [15:0] mul_out;
  logic        res_valid;
  logic        res_ready;
  logic [15:0] res_prod;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mult_op_seq #(.ACC_LAG(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .mul_a     (mul_a),
    .mul_b     (mul_b),
    .mul_state (mul_state),
    .mul_out   (mul_out),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_prod  (res_prod),
    .busy      (busy)
  );

  // Multiplier model: phase k adds one nibble partial product, visible next cycle.
  logic [1:0]  m_state = 2'd2;
  logic [15:0] m_acc   = 16'h1234;
  logic        preload = 1'b0;
  logic [15:0] preload_val = 16'h0000;

  function automatic logic [15:0] pp(input logic [1:0] k, input logic [7:0] a, input logic [7:0] b);
    logic [15:0] r;
    case (k)
      2'd0: r = 16'(a[3:0] * b[3:0]);
      2'd1: r = 16'(a[7:4] * b[3:0]) << 4;
      2'd2: r = 16'(a[3:0] * b[7:4]) << 4;
      default: r = 16'(a[7:4] * b[7:4]) << 8;
    endcase
    return r;
  endfunction

  always @(posedge clk) begin
    m_state <= m_state + 2'd1;
    if (preload) m_acc <= preload_val;
    else         m_acc <= m_acc + pp(m_state, mul_a, mul_b);
  end

  assign mul_state = m_state;
  assign mul_out   = m_acc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_phase(input int phase);
    for (int i = 0; i < 8 && phase < 4 && int'(m_state) != phase; i++) @(negedge clk);
  endtask

  task automatic handshake(input string tag);
    res_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    res_ready = 1'b0;
    check({tag, " res_valid after hs"}, 32'(res_valid), 32'd0);
    check({tag, " in_ready after hs"},  32'(in_ready),  32'd1);
    check({tag, " busy after hs"},      32'(busy),      32'd0);
  endtask

  // phase 0..3 forces the accept onto that mul_state; 4 accepts immediately.
  task automatic run_txn(input logic [7:0] a, input logic [7:0] b, input int phase,
                         input logic [15:0] exp, input string tag);
    int  p, n, hold_bad, rdy_bad;
    bit  got;
    @(negedge clk);
    wait_phase(phase);
    p = int'(m_state);
    in_a = a; in_b = b; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; in_a = ~a; in_b = ~b;
    hold_bad = 0; rdy_bad = 0; got = 1'b0; n = 0;
    if (in_ready !== 1'b0 || busy !== 1'b1) rdy_bad++;
    for (int i = 0; i < 20 && !got; i++) begin
      @(posedge clk); n++;
      @(negedge clk);
      if (mul_a !== a || mul_b !== b) hold_bad++;
      if (in_ready !== 1'b0 || busy !== 1'b1) rdy_bad++;
      if (res_valid === 1'b1) got = 1'b1;
    end
    check({tag, " latency"},  32'(n), 32'(5 + ((3 - p) & 3)));
    check({tag, " res_prod"}, 32'(res_prod), 32'(exp));
    check({tag, " operand hold"}, 32'(hold_bad), 32'd0);
    check({tag, " ready/busy"}, 32'(rdy_bad), 32'd0);
    handshake(tag);
  endtask

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    int          phase;
    logic [15:0] prod;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int n;
    bit got;
    int stall_bad;

    vecs[0] = '{8'h0C, 8'h0A, 4, 16'h0078};
    vecs[1] = '{8'hFF, 8'hFF, 4, 16'hFE01};
    vecs[2] = '{8'h00, 8'h37, 4, 16'h0000};
    vecs[3] = '{8'h12, 8'h34, 0, 16'h03A8};
    vecs[4] = '{8'h12, 8'h34, 1, 16'h03A8};
    vecs[5] = '{8'h12, 8'h34, 2, 16'h03A8};
    vecs[6] = '{8'h12, 8'h34, 3, 16'h03A8};
    vecs[7] = '{8'hA5, 8'h5A, 1, 16'h3A02};
    vecs[8] = '{8'h80, 8'h02, 2, 16'h0100};
    vecs[9] = '{8'h01, 8'h01, 3, 16'h0001};

    rst = 1'b1; in_valid = 1'b0; in_a = 8'h00; in_b = 8'h00; res_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst in_ready",  32'(in_ready),  32'd1);
    check("rst res_valid", 32'(res_valid), 32'd0);
    check("rst res_prod",  32'(res_prod),  32'd0);
    check("rst mul_a",     32'(mul_a),     32'd0);
    check("rst mul_b",     32'(mul_b),     32'd0);
    check("rst busy",      32'(busy),      32'd0);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      run_txn(vecs[i].a, vecs[i].b, vecs[i].phase, vecs[i].prod, $sformatf("vec%0d", i));
    end

    // Accumulator wrap: preload 0xFFF0 on the accept edge (phase 3, so t0 follows).
    @(negedge clk);
    wait_phase(3);
    preload = 1'b1; preload_val = 16'hFFF0;
    in_a = 8'h04; in_b = 8'h08; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    preload = 1'b0; in_valid = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("wrap mul_out", 32'(mul_out), 32'h0010);
    check("wrap early valid", 32'(res_valid), 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("wrap res_valid", 32'(res_valid), 32'd1);
    check("wrap res_prod",  32'(res_prod),  32'h0020);
    handshake("wrap");

    // Backpressure in DONE with in_valid held high throughout.
    @(negedge clk);
    in_a = 8'h21; in_b = 8'h03; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_a = 8'h77; in_b = 8'h02;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (res_valid === 1'b1) got = 1'b1;
    end
    check("stall reached done", 32'(got), 32'd1);
    check("stall res_prod", 32'(res_prod), 32'h0063);
    stall_bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (res_valid !== 1'b1 || res_prod !== 16'h0063 || in_ready !== 1'b0 ||
          mul_a !== 8'h21 || mul_b !== 8'h03) stall_bad++;
    end
    check("stall hold", 32'(stall_bad), 32'd0);
    res_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    res_ready = 1'b0;
    check("stall hs in_ready", 32'(in_ready),  32'd1);
    check("stall hs res_valid", 32'(res_valid), 32'd0);
    check("stall hs mul_a", 32'(mul_a), 32'h21);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check("stall next accept in_ready", 32'(in_ready), 32'd0);
    check("stall next accept mul_a", 32'(mul_a), 32'h77);
    check("stall next accept mul_b", 32'(mul_b), 32'h02);
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (res_valid === 1'b1) got = 1'b1;
    end
    check("stall second prod", 32'(res_prod), 32'h00EE);
    handshake("stall2");

    // Reset pulsed in the second RUN cycle.
    @(negedge clk);
    wait_phase(3);
    in_a = 8'h55; in_b = 8'h03; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("midrun rst in_ready",  32'(in_ready),  32'd1);
    check("midrun rst res_valid", 32'(res_valid), 32'd0);
    check("midrun rst res_prod",  32'(res_prod),  32'd0);
    check("midrun rst mul_a",     32'(mul_a),     32'd0);
    check("midrun rst mul_b",     32'(mul_b),     32'd0);
    check("midrun rst busy",      32'(busy),      32'd0);
    run_txn(8'h10, 8'h10, 4, 16'h0100, "post_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
